// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the multi-channel pulse stretcher.
// Holds the channel state encoding, default window/gap lengths and counter sizing.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int STRETCH_DEF = 3;
    localparam int GAP_DEF     = 2;

    // Counter must hold the larger of STRETCH-1 and GAP-1.
    function automatic int calc_cnt_w(input int stretch, input int gap);
        int m;
        m = (stretch > gap) ? stretch : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_mc_if.sv
// Event/status bundle between the pulse stretcher and its user.
// master drives events and overrun clears; slave (the stretcher) returns the status vectors.
interface pulse_stretch_mc_if #(
    parameter int CH = 4
);
    logic [CH-1:0] i_pulse;
    logic [CH-1:0] i_clr_ovr;
    logic [CH-1:0] o_pulse;
    logic [CH-1:0] o_busy;
    logic [CH-1:0] o_drop;
    logic [CH-1:0] o_overrun;

    modport master (
        output i_pulse, i_clr_ovr,
        input  o_pulse, o_busy, o_drop, o_overrun
    );

    modport slave (
        input  i_pulse, i_clr_ovr,
        output o_pulse, o_busy, o_drop, o_overrun
    );
endinterface

// File: rtl/pulse_stretch_ch.sv
// One stretcher channel: window/gap FSM with down-counter, one-deep pending event,
// drop strobe and sticky overrun. All outputs are registered from next-state values.
//
// state  | meaning
// IDLE   | no window active, ready for an event
// HIGH   | output window asserted, counting STRETCH cycles
// GAP    | enforced low time, counting GAP cycles
module pulse_stretch_ch
    import pulse_stretch_pkg::*;
#(
    parameter int STRETCH = STRETCH_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_event,
    input  logic i_clr_ovr,
    output logic o_pulse,
    output logic o_busy,
    output logic o_drop,
    output logic o_overrun
);

    localparam int CNT_W = calc_cnt_w(STRETCH, GAP);
    localparam logic [CNT_W-1:0] LOAD_HIGH = CNT_W'(STRETCH - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_HIGH = ST_HIGH;
    localparam logic [1:0] S_GAP  = ST_GAP;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend, pend_nxt;
    logic             drop_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        drop_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_event) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = LOAD_HIGH;
                end
            end
            S_HIGH, S_GAP: begin
                if (cnt != '0 || (state == S_HIGH && GAP > 0)) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = LOAD_GAP;
                    end
                    if (i_event) begin
                        if (pend) drop_nxt = 1'b1;
                        else      pend_nxt = 1'b1;
                    end
                end else if (pend || i_event) begin
                    // Window boundary: a held or same-cycle event starts the next
                    // window at once; an event that arrives while one is held re-arms.
                    state_nxt = S_HIGH;
                    cnt_nxt   = LOAD_HIGH;
                    pend_nxt  = pend & i_event;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            o_pulse   <= 1'b0;
            o_busy    <= 1'b0;
            o_drop    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend      <= pend_nxt;
            o_pulse   <= (state_nxt == S_HIGH);
            o_busy    <= (state_nxt != S_IDLE) | pend_nxt;
            o_drop    <= drop_nxt;
            if (drop_nxt)       o_overrun <= 1'b1;
            else if (i_clr_ovr) o_overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_stretch_mc.sv
// CH-channel pulse stretcher on the fast side of a fast-to-slow pulse crossing.
// Define PULSE_STRETCH_SYNC_EN to synchronise i_pulse and count rising edges as events.
module pulse_stretch_mc
    import pulse_stretch_pkg::*;
#(
    parameter int CH      = 4,
    parameter int STRETCH = STRETCH_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    pulse_stretch_mc_if.slave bus
);

    logic [CH-1:0] evt;
    logic [CH-1:0] pulse_v, busy_v, drop_v, ovr_v;

`ifdef PULSE_STRETCH_SYNC_EN
    logic [CH-1:0] sync_q1, sync_q2, sync_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            sync_d  <= '0;
        end else begin
            sync_q1 <= bus.i_pulse;
            sync_q2 <= sync_q1;
            sync_d  <= sync_q2;
        end
    end

    assign evt = sync_q2 & ~sync_d;
`else
    assign evt = bus.i_pulse;
`endif

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pulse_stretch_ch #(
            .STRETCH (STRETCH),
            .GAP     (GAP)
        ) u_ch (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_event   (evt[k]),
            .i_clr_ovr (bus.i_clr_ovr[k]),
            .o_pulse   (pulse_v[k]),
            .o_busy    (busy_v[k]),
            .o_drop    (drop_v[k]),
            .o_overrun (ovr_v[k])
        );
    end

    assign bus.o_pulse   = pulse_v;
    assign bus.o_busy    = busy_v;
    assign bus.o_drop    = drop_v;
    assign bus.o_overrun = ovr_v;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Bench for pulse_stretch_mc: a GAP=2 and a GAP=0 instance share stimulus and are
// compared every cycle against a window-scheduling model plus hand-derived tables.
module tb_pulse_stretch_mc;

    localparam int CH   = 4;
    localparam int S    = 3;
    localparam int NCYC = 1024;

    typedef struct {
        int            from;
        int            to;
        logic [CH-1:0] pulse;
        logic [CH-1:0] clr;
    } stim_t;

    typedef struct {
        int   d;
        int   ch;
        int   c;
        logic p;
        logic b;
        logic dr;
        logic o;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset;
    always #5 i_clk = ~i_clk;

    pulse_stretch_mc_if #(.CH(CH)) bus0 ();
    pulse_stretch_mc_if #(.CH(CH)) bus1 ();

    pulse_stretch_mc #(.CH(CH), .STRETCH(S), .GAP(2)) dut0 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus0)
    );

    pulse_stretch_mc #(.CH(CH), .STRETCH(S), .GAP(0)) dut1 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus1)
    );

    logic [CH-1:0] ep [2][NCYC];
    logic [CH-1:0] eb [2][NCYC];
    logic [CH-1:0] ed [2][NCYC];
    logic [CH-1:0] ap [2][NCYC];
    logic [CH-1:0] ab [2][NCYC];
    logic [CH-1:0] ad [2][NCYC];
    logic [CH-1:0] ao [2][NCYC];
    logic [CH-1:0] clr_h [NCYC];
    logic [CH-1:0] ovr_m [2];
    logic [CH-1:0] prev_in;
    int            last_start [2][CH];
    int            cyc;
    int            checks = 0;
    int            errors = 0;

    stim_t stim[$];
    exp_t  xt[$];

    function automatic int gap_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input int c, input logic [CH-1:0] act,
                       input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %b exp %b", name, c, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input int d, input int ch, input int c,
                           input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d ch%0d cyc %0d got %b exp %b", name, d, ch, c, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCYC; c++) begin
                ep[d][c] = '0; eb[d][c] = '0; ed[d][c] = '0;
                ap[d][c] = '0; ab[d][c] = '0; ad[d][c] = '0; ao[d][c] = '0;
            end
            for (int k = 0; k < CH; k++) last_start[d][k] = -100;
            ovr_m[d] = '0;
        end
        for (int c = 0; c < NCYC; c++) clr_h[c] = '0;
        prev_in = '0;
    endtask

    // An event at cycle e is dropped if a window is already booked to start after e+1;
    // otherwise its window starts as soon as the previous window plus gap allows.
    task automatic model_event(input int d, input int ch, input int e);
        int start;
        if (last_start[d][ch] > e + 1) begin
            if (e + 1 < NCYC) ed[d][e+1][ch] = 1'b1;
        end else begin
            start = last_start[d][ch] + S + gap_of(d);
            if (start < e + 1) start = e + 1;
            for (int c = start; c < start + S && c < NCYC; c++) ep[d][c][ch] = 1'b1;
            for (int c = e + 1; c < start + S + gap_of(d) && c < NCYC; c++) eb[d][c][ch] = 1'b1;
            last_start[d][ch] = start;
        end
    endtask

    task automatic model_update(input int c, input logic [CH-1:0] p, input logic [CH-1:0] clr);
        logic ev;
        int   e;
        clr_h[c] = clr;
        for (int k = 0; k < CH; k++) begin
`ifdef PULSE_STRETCH_SYNC_EN
            ev = p[k] & ~prev_in[k];
            e  = c + 2;
`else
            ev = p[k];
            e  = c;
`endif
            if (ev) for (int d = 0; d < 2; d++) model_event(d, k, e);
        end
        prev_in = p;
    endtask

    task automatic compare(input int c);
        logic [CH-1:0] p, b, dr, o;
        for (int d = 0; d < 2; d++) begin
            if (c > 0) ovr_m[d] = ed[d][c] | (ovr_m[d] & ~clr_h[c-1]);
            else       ovr_m[d] = ed[d][c];
            if (d == 0) begin
                p = bus0.o_pulse; b = bus0.o_busy; dr = bus0.o_drop; o = bus0.o_overrun;
            end else begin
                p = bus1.o_pulse; b = bus1.o_busy; dr = bus1.o_drop; o = bus1.o_overrun;
            end
            ap[d][c] = p; ab[d][c] = b; ad[d][c] = dr; ao[d][c] = o;
            chk($sformatf("pulse%0d", d), c, p, ep[d][c]);
            chk($sformatf("busy%0d", d), c, b, eb[d][c]);
            chk($sformatf("drop%0d", d), c, dr, ed[d][c]);
            chk($sformatf("ovr%0d", d), c, o, ovr_m[d]);
        end
    endtask

    task automatic drive(input logic [CH-1:0] p, input logic [CH-1:0] clr);
        bus0.i_pulse = p; bus0.i_clr_ovr = clr;
        bus1.i_pulse = p; bus1.i_clr_ovr = clr;
    endtask

    task automatic run_cycle(input logic [CH-1:0] p, input logic [CH-1:0] clr);
        @(negedge i_clk);
        compare(cyc);
        drive(p, clr);
        model_update(cyc, p, clr);
        cyc++;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        drive('0, '0);
        model_clear();
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        logic [CH-1:0] p, clr;

`ifdef PULSE_STRETCH_SYNC_EN
        stim.push_back('{10, 30, 4'b1000, 4'b0000});
        stim.push_back('{40, 40, 4'b0001, 4'b0000});
        xt.push_back('{0, 3, 12, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 3, 13, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 15, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 16, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 18, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 3, 31, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 3, 35, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{1, 3, 16, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 0, 42, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 0, 43, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 0, 46, 1'b0, 1'b1, 1'b0, 1'b0});
`else
        stim.push_back('{10, 10, 4'b1111, 4'b0000});
        stim.push_back('{11, 11, 4'b0110, 4'b0000});
        stim.push_back('{12, 12, 4'b0100, 4'b0000});
        stim.push_back('{15, 15, 4'b1000, 4'b0000});
        stim.push_back('{20, 20, 4'b0000, 4'b0100});
        stim.push_back('{40, 40, 4'b1000, 4'b0000});
        stim.push_back('{43, 43, 4'b1000, 4'b0000});
        xt.push_back('{0, 0, 10, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 0, 11, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 0, 13, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 0, 14, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 0, 15, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 0, 16, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 1, 15, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 1, 16, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 1, 18, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 1, 19, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 1, 21, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 2, 12, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 2, 13, 1'b1, 1'b1, 1'b1, 1'b1});
        xt.push_back('{0, 2, 14, 1'b0, 1'b1, 1'b0, 1'b1});
        xt.push_back('{0, 2, 16, 1'b1, 1'b1, 1'b0, 1'b1});
        xt.push_back('{0, 2, 20, 1'b0, 1'b1, 1'b0, 1'b1});
        xt.push_back('{0, 2, 21, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{0, 3, 15, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 16, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 44, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 46, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 49, 1'b0, 1'b1, 1'b0, 1'b0});
        xt.push_back('{0, 3, 51, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{1, 0, 14, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{1, 1, 13, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 1, 14, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 1, 16, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 1, 17, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{1, 2, 13, 1'b1, 1'b1, 1'b1, 1'b1});
        xt.push_back('{1, 2, 14, 1'b1, 1'b1, 1'b0, 1'b1});
        xt.push_back('{1, 3, 14, 1'b0, 1'b0, 1'b0, 1'b0});
        xt.push_back('{1, 3, 16, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 3, 43, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 3, 44, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 3, 46, 1'b1, 1'b1, 1'b0, 1'b0});
        xt.push_back('{1, 3, 47, 1'b0, 1'b0, 1'b0, 1'b0});
`endif

        // Directed scenario, model-checked every cycle, then table-checked.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            p = '0; clr = '0;
            foreach (stim[i]) begin
                if (c >= stim[i].from && c <= stim[i].to) begin
                    p   |= stim[i].pulse;
                    clr |= stim[i].clr;
                end
            end
            run_cycle(p, clr);
        end
        foreach (xt[i]) begin
            chk_bit("tbl_pulse", xt[i].d, xt[i].ch, xt[i].c, ap[xt[i].d][xt[i].c][xt[i].ch], xt[i].p);
            chk_bit("tbl_busy",  xt[i].d, xt[i].ch, xt[i].c, ab[xt[i].d][xt[i].c][xt[i].ch], xt[i].b);
            chk_bit("tbl_drop",  xt[i].d, xt[i].ch, xt[i].c, ad[xt[i].d][xt[i].c][xt[i].ch], xt[i].dr);
            chk_bit("tbl_ovr",   xt[i].d, xt[i].ch, xt[i].c, ao[xt[i].d][xt[i].c][xt[i].ch], xt[i].o);
        end

        // Reset asserted mid-window with an event held pending.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            p = (c == 10 || c == 11) ? 4'b0001 : 4'b0000;
            run_cycle(p, '0);
        end
        #2 i_reset = 1'b0;
        #1;
        chk("rst_pulse0", cyc, bus0.o_pulse, '0);
        chk("rst_busy0",  cyc, bus0.o_busy, '0);
        chk("rst_pulse1", cyc, bus1.o_pulse, '0);
        chk("rst_busy1",  cyc, bus1.o_busy, '0);
        chk("rst_drop",   cyc, bus0.o_drop | bus1.o_drop, '0);
        chk("rst_ovr",    cyc, bus0.o_overrun | bus1.o_overrun, '0);
        repeat (2) @(negedge i_clk);
        model_clear();
        i_reset = 1'b1;
        cyc = 0;
        for (int c = 0; c < 20; c++) run_cycle('0, '0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 700; c++) begin
            for (int k = 0; k < CH; k++) begin
                p[k]   = ($urandom_range(0, 99) < 30);
                clr[k] = ($urandom_range(0, 99) < 5);
            end
            run_cycle(p, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
